// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the mem_responder memory port.
// Alignment checking is enabled by defining MEM_RSP_ALIGN_CHECK_EN.
package mem_rsp_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [1:0] aligned_lane(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [1:0] lane;
    case (size)
      SIZE_WORD: lane = 2'b00;
      SIZE_HALF: lane = {lo[1], 1'b0};
      default:   lane = lo;
    endcase
    return lane;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return ((size == SIZE_WORD) && (lo != 2'b00)) ||
           ((size == SIZE_HALF) && lo[0]);
  endfunction

endpackage

// File: rtl/mem_rsp_lane_merge.sv
// Combinational store merge and zero-extended load extract for one word.
// Little-endian lanes: byte 0 is bits 7:0.
module mem_rsp_lane_merge
  import mem_rsp_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  always_comb begin
    merged_o = old_i;
    load_o   = old_i;
    case (size_i)
      SIZE_HALF: begin
        if (lane_i[1]) begin
          merged_o[31:16] = wdata_i[15:0];
          load_o = {16'h0, old_i[31:16]};
        end else begin
          merged_o[15:0] = wdata_i[15:0];
          load_o = {16'h0, old_i[15:0]};
        end
      end
      SIZE_BYTE: begin
        merged_o[8*lane_i +: 8] = wdata_i[7:0];
        load_o = {24'h0, old_i[8*lane_i +: 8]};
      end
      default: begin
        merged_o = wdata_i;
        load_o   = old_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-stated word memory responder with valid/ready request port.
// Define MEM_RSP_ALIGN_CHECK_EN to flag misaligned word/half accesses.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q;
  logic [1:0]      size_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            accept;
  logic            do_access;
  logic            oob;
  logic            bad_size;
  logic            misal;
  logic            err;
  logic            mem_we;
  logic [1:0]      lane;
  logic [IW-1:0]   idx;
  logic [31:0]     old_word;
  logic [31:0]     merged;
  logic [31:0]     load_val;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;
  assign do_access = (state_q == ACCESS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else cnt_d = cnt_q - 1'b1;
      end
      ACCESS: state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lane     = aligned_lane(size_q, addr_q[1:0]);
  assign oob      = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
  assign bad_size = (size_q == 2'b11);
`ifdef MEM_RSP_ALIGN_CHECK_EN
  assign misal    = misaligned(size_q, addr_q[1:0]);
`else
  assign misal    = 1'b0;
`endif
  assign err      = oob || bad_size || misal;
  assign idx      = addr_q[IW+1:2];
  assign old_word = mem_q[idx];
  assign mem_we   = do_access && write_q && !err;

  mem_rsp_lane_merge u_merge (
    .old_i    (old_word),
    .wdata_i  (wdata_q),
    .size_i   (size_q),
    .lane_i   (lane),
    .merged_o (merged),
    .load_o   (load_val)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response fields change only on the access edge and hold until the next one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      err_q   <= err;
      rdata_q <= (err || write_q) ? 32'h0 : load_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= merged;
    end
  end

endmodule
